// File: rtl/hs_pulse_tx_multi.sv
// Multi-channel four-phase req/ack sender: per-channel pending capture, round-robin
// arbitration, ack synchroniser, overrun and ack-timeout reporting.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | no transfer; grants the next pending channel once ack_s is low
// REQ     | req_out high, waiting for ack_s or the timeout
// RELEASE | req_out low, waiting for ack_s to return low
module hs_pulse_tx_multi #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 8,
    parameter int CH_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                     clk1,
    input  logic                     sys_rst,
    input  logic [N_CH-1:0]          pulse_in,
    input  logic [N_CH*DATA_W-1:0]   din,
    input  logic                     ack_in,
    input  logic                     clr_err,
    output logic                     req_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [CH_W-1:0]          ch_out,
    output logic                     done_pulse,
    output logic [CH_W-1:0]          done_ch,
    output logic                     busy,
    output logic [N_CH-1:0]          overrun,
    output logic                     timeout_err,
    output logic [CH_W-1:0]          err_ch
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CH_W:0]  N_CH_X   = (CH_W+1)'(N_CH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [1:0]             state_q, state_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_CH-1:0]        pend_q;
    logic [DATA_W-1:0]      buf_q [N_CH];
    logic [DATA_W-1:0]      data_q;
    logic [CH_W-1:0]        ch_q;
    logic [CH_W-1:0]        rr_q;
    logic                   done_q;
    logic [CH_W-1:0]        done_ch_q;
    logic [N_CH-1:0]        ovr_q;
    logic                   to_err_q;
    logic [CH_W-1:0]        err_ch_q;

    logic                   grant_fire, done_set, to_set;
    logic [2*N_CH-1:0]      pend_dbl;
    logic [N_CH-1:0]        pend_rot;
    logic [CH_W-1:0]        gnt_off, gnt_idx, rr_nxt;
    logic [CH_W:0]          gnt_sum, rr_sum;
    logic [N_CH-1:0]        gnt_oh;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Rotate pending so bit 0 is the rr_q channel; the lowest set bit is the winner.
    assign pend_dbl = {pend_q, pend_q};
    assign pend_rot = N_CH'(pend_dbl >> rr_q);

    always_comb begin
        gnt_off = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (pend_rot[j]) gnt_off = CH_W'(j);
        end
        gnt_sum = {1'b0, rr_q} + {1'b0, gnt_off};
        gnt_idx = (gnt_sum >= N_CH_X) ? CH_W'(gnt_sum - N_CH_X) : CH_W'(gnt_sum);
        rr_sum  = {1'b0, gnt_idx} + (CH_W+1)'(1);
        rr_nxt  = (rr_sum == N_CH_X) ? '0 : CH_W'(rr_sum);
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        grant_fire = 1'b0;
        done_set   = 1'b0;
        to_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|pend_q) && !ack_s) begin
                    grant_fire = 1'b1;
                    req_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (ack_s) begin
                    req_d    = 1'b0;
                    done_set = 1'b1;
                    state_d  = S_REL;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    to_set  = 1'b1;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!ack_s) state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_oh[i] = grant_fire && (gnt_idx == CH_W'(i));
        end
    end

    always_ff @(posedge clk1) begin
        if (sys_rst) begin
            sync_q    <= '0;
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= '0;
            data_q    <= '0;
            ch_q      <= '0;
            rr_q      <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            ovr_q     <= '0;
            to_err_q  <= 1'b0;
            err_ch_q  <= '0;
            for (int i = 0; i < N_CH; i++) buf_q[i] <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_in};
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            done_q  <= done_set;
            if (grant_fire) begin
                data_q <= buf_q[gnt_idx];
                ch_q   <= gnt_idx;
                rr_q   <= rr_nxt;
            end
            if (done_set) done_ch_q <= ch_q;
            // Clears come first so a same-edge set overrides them.
            if (clr_err) begin
                ovr_q    <= '0;
                to_err_q <= 1'b0;
            end
            if (to_set) begin
                to_err_q <= 1'b1;
                err_ch_q <= ch_q;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (pulse_in[i]) begin
                    if (!pend_q[i] || gnt_oh[i]) begin
                        pend_q[i] <= 1'b1;
                        buf_q[i]  <= din[i*DATA_W +: DATA_W];
                    end else begin
                        ovr_q[i] <= 1'b1;
                    end
                end else if (gnt_oh[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign req_out     = req_q;
    assign data_out    = data_q;
    assign ch_out      = ch_q;
    assign done_pulse  = done_q;
    assign done_ch     = done_ch_q;
    assign busy        = (state_q != S_IDLE) || (|pend_q);
    assign overrun     = ovr_q;
    assign timeout_err = to_err_q;
    assign err_ch      = err_ch_q;

endmodule
